// File: rtl/psubsb_seq_pkg.sv
// rtl/psubsb_seq_pkg.sv - shared state encoding, lane geometry and saturation constants
package psubsb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          LANES     = 4;
    localparam int          LANE_W    = 4;
    localparam logic [1:0]  LANE_LAST = 2'(LANES - 1);
    localparam logic [3:0]  SAT_POS   = 4'h7;
    localparam logic [3:0]  SAT_NEG   = 4'h8;

    // Overflow direction follows the minuend sign: a non-negative minuend can only overflow upward.
    function automatic logic [3:0] saturate(input logic [3:0] raw, input logic ovf, input logic a_sign);
        if (!ovf)
            return raw;
        return a_sign ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/psubsb_seq_if.sv
// rtl/psubsb_seq_if.sv - request/result bundle for the packed saturating subtractor
interface psubsb_seq_if;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic [3:0]  Sat;

    modport master (output start, A, B, input busy, done, Diff, Sat);
    modport slave  (input start, A, B, output busy, done, Diff, Sat);
endinterface

// File: rtl/addsub_4bit.sv
// rtl/addsub_4bit.sv - 4-bit two's complement adder/subtractor with signed overflow flag
module addsub_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    output logic [3:0] sum,
    output logic       ovf
);
    logic [3:0] b_eff;

    assign b_eff = b ^ {4{sub}};
    assign sum   = a + b_eff + {3'b000, sub};
    // Signed overflow: like-signed effective operands producing an opposite-signed result.
    assign ovf   = (a[3] == b_eff[3]) && (sum[3] != a[3]);
endmodule

// File: rtl/psubsb_seq.sv
// rtl/psubsb_seq.sv - sequential packed 4x4-bit saturating subtract, one lane per cycle
module psubsb_seq
    import psubsb_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    psubsb_seq_if.slave  bus
);
    state_t      state, state_nx;
    logic [1:0]  lane;
    logic [15:0] a_q, b_q, diff_q;
    logic [3:0]  sat_q;
    logic        accept;
    logic [3:0]  a_lane, b_lane, raw, lane_res;
    logic        ovf;

    assign accept = bus.start && (state != CALC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = CALC;
            CALC:    if (lane == LANE_LAST) state_nx = DONE;
            DONE:    state_nx = bus.start ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Single shared lane datapath, operands selected by the current lane index.
    assign a_lane = 4'(a_q >> {lane, 2'b00});
    assign b_lane = 4'(b_q >> {lane, 2'b00});

    addsub_4bit u_lane (
        .a   (a_lane),
        .b   (b_lane),
        .sub (1'b1),
        .sum (raw),
        .ovf (ovf)
    );

    assign lane_res = saturate(raw, ovf, a_lane[3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            lane   <= '0;
            diff_q <= '0;
            sat_q  <= '0;
        end else if (accept) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            lane   <= '0;
            diff_q <= '0;
            sat_q  <= '0;
        end else if (state == CALC) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane == i[1:0]) begin
                    diff_q[i*LANE_W +: LANE_W] <= lane_res;
                    sat_q[i]                   <= ovf;
                end
            end
            lane <= lane + 2'd1;
        end
    end

    assign bus.busy = (state == CALC);
    assign bus.done = (state == DONE);
    assign bus.Diff = diff_q;
    assign bus.Sat  = sat_q;
endmodule

// File: tb/tb_psubsb_seq.sv
// tb/tb_psubsb_seq.sv - directed self-checking bench for psubsb_seq
module tb_psubsb_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    psubsb_seq_if bus ();

    psubsb_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic watch(input int cycles, output int first, output int count);
        first = 0;
        count = 0;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            if (bus.done) begin
                count++;
                if (first == 0) first = i;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({bus.busy, bus.done, bus.Diff, bus.Sat} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b Diff=%h Sat=%b want all zero",
                     bus.busy, bus.done, bus.Diff, bus.Sat);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vector(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] exp_diff, input logic [3:0] exp_sat);
        int first, count;
        launch(a, b);
        watch(8, first, count);
        total++;
        if (first !== 5 || count !== 1) begin
            bad++;
            $display("FAIL %s_done: got first=%0d count=%0d want first=5 count=1", name, first, count);
        end
        total++;
        if (bus.Diff !== exp_diff || bus.Sat !== exp_sat) begin
            bad++;
            $display("FAIL %s_result: got Diff=%h Sat=%b want Diff=%h Sat=%b",
                     name, bus.Diff, bus.Sat, exp_diff, exp_sat);
        end
    endtask

    task automatic test_busy();
        launch(16'h1234, 16'h0111);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            total++;
            if (bus.busy !== (i <= 4)) begin
                bad++;
                $display("FAIL busy_cycle%0d: got %b want %b", i, bus.busy, (i <= 4));
            end
        end
    endtask

    task automatic test_hold_start();
        int first = 0;
        int count = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'h7812;
        bus.B     = 16'hF111;
        @(posedge clk);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (bus.done) begin
                count++;
                if (first == 0) first = i;
            end
            bus.start = (i <= 4);
            bus.A     = 16'($urandom);
            bus.B     = 16'($urandom);
        end
        total++;
        if (first !== 5 || count !== 1) begin
            bad++;
            $display("FAIL hold_done: got first=%0d count=%0d want first=5 count=1", first, count);
        end
        total++;
        if (bus.Diff !== 16'h7801 || bus.Sat !== 4'b1100) begin
            bad++;
            $display("FAIL hold_result: got Diff=%h Sat=%b want Diff=7801 Sat=1100", bus.Diff, bus.Sat);
        end
    endtask

    task automatic test_back_to_back();
        int first, count;
        launch(16'h1234, 16'h0111);
        watch(5, first, count);
        total++;
        if (!bus.done || bus.Diff !== 16'h1123 || bus.Sat !== 4'b0000) begin
            bad++;
            $display("FAIL b2b_first: got done=%b Diff=%h Sat=%b want done=1 Diff=1123 Sat=0000",
                     bus.done, bus.Diff, bus.Sat);
        end
        bus.start = 1'b1;
        bus.A     = 16'h0000;
        bus.B     = 16'h8888;
        @(posedge clk);
        #1 bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.Diff !== 16'h0000 || bus.Sat !== 4'b0000) begin
            bad++;
            $display("FAIL b2b_accept: got busy=%b Diff=%h Sat=%b want busy=1 Diff=0000 Sat=0000",
                     bus.busy, bus.Diff, bus.Sat);
        end
        watch(6, first, count);
        total++;
        if (first !== 5 || count !== 1 || bus.Diff !== 16'h7777 || bus.Sat !== 4'b1111) begin
            bad++;
            $display("FAIL b2b_second: got first=%0d count=%0d Diff=%h Sat=%b want 5 1 7777 1111",
                     first, count, bus.Diff, bus.Sat);
        end
    endtask

    task automatic test_reset_mid_calc();
        int first, count;
        launch(16'h0000, 16'h0008);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b1 || bus.Diff !== 16'h0007 || bus.Sat !== 4'b0001) begin
            bad++;
            $display("FAIL midcalc_partial: got busy=%b Diff=%h Sat=%b want busy=1 Diff=0007 Sat=0001",
                     bus.busy, bus.Diff, bus.Sat);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.Diff, bus.Sat} !== 22'd0) begin
            bad++;
            $display("FAIL midcalc_async_clear: got busy=%b done=%b Diff=%h Sat=%b want all zero",
                     bus.busy, bus.done, bus.Diff, bus.Sat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        watch(10, first, count);
        total++;
        if (count !== 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL midcalc_no_done: got done_count=%0d busy=%b want 0 0", count, bus.busy);
        end
    endtask

    task automatic test_start_after_reset();
        int first, count;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b1;
        bus.A     = 16'h8F80;
        bus.B     = 16'h0700;
        @(posedge clk);
        #1 bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_accept: got busy=%b want 1", bus.busy);
        end
        watch(6, first, count);
        total++;
        if (first !== 5 || count !== 1 || bus.Diff !== 16'h8880 || bus.Sat !== 4'b0000) begin
            bad++;
            $display("FAIL post_reset_result: got first=%0d count=%0d Diff=%h Sat=%b want 5 1 8880 0000",
                     first, count, bus.Diff, bus.Sat);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A     = 16'h0000;
        bus.B     = 16'h0000;
        test_reset();
        test_vector("basic", 16'h1234, 16'h0111, 16'h1123, 4'b0000);
        test_vector("mixed_sat", 16'h7812, 16'hF111, 16'h7801, 4'b1100);
        test_vector("pos_sat_all", 16'h0000, 16'h8888, 16'h7777, 4'b1111);
        test_vector("neg_edge", 16'h8F80, 16'h0700, 16'h8880, 4'b0000);
        test_vector("small", 16'h8000, 16'h0001, 16'h800F, 4'b0000);
        test_busy();
        test_hold_start();
        test_back_to_back();
        test_reset_mid_calc();
        test_start_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/psubsb_seq.md
PSUBSB_SEQ -- requirements
Module: psubsb_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: start  input  1  request a new packed subtract.
REQ-004 SHALL have port: A  input  16  minuend; four signed 4-bit lanes, lane3 = A[15:12] ... lane0 = A[3:0].
REQ-005 SHALL have port: B  input  16  subtrahend, with the same lane layout as A.
REQ-006 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-007 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port: Diff  output  16  packed saturated differences {sat(A3-B3), sat(A2-B2), sat(A1-B1), sat(A0-B0)}.
REQ-009 SHALL have port: Sat  output  4  per-lane saturation flags; Sat[i] = 1 when lane i saturated.

Function
REQ-010 SHALL implement the states IDLE, CALC and DONE.
REQ-011 SHALL accept start only in IDLE or DONE; at that edge it latches A and B, clears the lane index to 0 and enters CALC.
REQ-012 SHALL ignore start while in CALC; input changes in CALC SHALL NOT affect the result.
REQ-013 SHALL, in CALC, process one lane per cycle in order lane0 to lane3, writing Diff and Sat for that lane at each edge.
REQ-014 SHALL leave CALC for DONE after the lane3 edge, so CALC lasts exactly 4 cycles.
REQ-015 SHALL assert done only in DONE, for exactly 1 cycle.
REQ-016 SHALL make done visible in the 5th cycle after the start-sampling edge.
REQ-017 SHALL move DONE to IDLE, or to CALC if start=1 in that cycle (back-to-back, no bubble).
REQ-018 SHALL drive busy=1 in CALC only.
REQ-019 SHALL treat lane arithmetic as 4-bit two's complement, computing A_i + ~B_i + 1.
REQ-020 SHALL detect overflow when the operand sign bits differ and the result sign differs from A_i's sign.
REQ-021 SHALL saturate positive overflow (A_i >= 0, B_i < 0) to 4'h7 and set Sat[i].
REQ-022 SHALL saturate negative overflow (A_i < 0, B_i >= 0) to 4'h8 and set Sat[i].
REQ-023 SHALL otherwise output the raw difference with Sat[i]=0.
REQ-024 SHALL clear Diff and Sat at the start-accept edge.
REQ-025 SHALL hold Diff and Sat stable from DONE until the next accepted start.
REQ-026 SHALL produce a correct result for the boundary case 0 - (-8), saturating to 4'h7.
REQ-027 SHALL produce a correct result for the boundary case -8 - 0, giving 4'h8 without saturation.
REQ-028 SHALL produce a correct result for the boundary case -1 - 7 = -8, giving 4'h8 with Sat=0.

Reset
REQ-029 SHALL, while rst_n=0, immediately force the state to IDLE, lane index to 0, busy=0, done=0, Diff=16'h0000, Sat=4'b0000 and the operand latches to 0.
REQ-030 SHALL abandon any operation in progress when reset is asserted mid-CALC; no done pulse follows it.
REQ-031 SHALL honor a start in the first cycle after rst_n deasserts.

Structure
REQ-032 SHALL place the state encoding (IDLE/CALC/DONE), lane count (4), lane width (4), SAT_POS=4'h7 and SAT_NEG=4'h8 in the shared execute package.
REQ-033 SHALL reuse the existing 4-bit add/sub sub-module addsub_4bit, with sub=1 and overflow output used, as the single lane datapath instance muxed by lane index.
REQ-034 SHALL use no other sub-modules.

Verification
REQ-035 SHALL cover: A=16'h1234, B=16'h0111, start pulse -> done in the 5th cycle, Diff=16'h1123, Sat=4'b0000.
REQ-036 SHALL cover: A=16'h7812, B=16'hF111 -> Diff=16'h7801, Sat=4'b1100.
REQ-037 SHALL cover: A=16'h0000, B=16'h8888 -> Diff=16'h7777, Sat=4'b1111; also A=16'h8F80, B=16'h0700 -> Diff=16'h8880, Sat=4'b0000.
REQ-038 SHALL cover: start held high and A/B toggled each cycle during CALC -> result matches operands latched at accept; exactly one done.
REQ-039 SHALL cover: rst_n low during the 2nd CALC cycle -> busy, done, Diff and Sat go to 0 asynchronously; no done after release.
REQ-040 SHALL cover: start asserted in the DONE cycle with new operands -> busy next cycle, second done exactly 5 cycles later, first result visible until that accept edge.
